neural_mem_loader: RTL and testbench
====================================

NEURAL_MEM_LOADER -- requirements
Module: neural_mem_loader

Interface
REQ-001: The parameter ADDR_W SHALL be defined as: ADDR_W, default 11, data-memory word-address width.
REQ-002: The parameter DATA_W SHALL be defined as: DATA_W, default 32, memory word width, Q16.16 payload.
REQ-003: The port clk SHALL be defined as: clk  input  1  single clock; all state changes on its rising edge.
REQ-004: The port rst SHALL be defined as: rst  input  1  reset, asynchronous, active-high.
REQ-005: The port start SHALL be defined as: start  input  1  one-cycle pulse that begins a load.
REQ-006: The port in_valid SHALL be defined as: in_valid  input  1  byte-stream data valid.
REQ-007: The port in_data SHALL be defined as: in_data  input  8  byte-stream data, little-endian words.
REQ-008: The port in_ready SHALL be defined as: in_ready  output  1  loader accepts a byte this cycle.
REQ-009: The port wr_en SHALL be defined as: wr_en  output  1  data-memory write strobe.
REQ-010: The port wr_addr SHALL be defined as: wr_addr  output  ADDR_W  data-memory write address.
REQ-011: The port wr_data SHALL be defined as: wr_data  output  DATA_W  data-memory write word.
REQ-012: The port busy SHALL be defined as: busy  output  1  load in progress.
REQ-013: The port done SHALL be defined as: done  output  1  image complete and valid, level.
REQ-014: The port error SHALL be defined as: error  output  1  header or size error, level.

Function
REQ-015: A byte SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-016: in_ready SHALL be 1 only in states HDR_TRAIN, HDR_TEST and PAYLOAD, and 0 otherwise.
REQ-017: Four accepted bytes SHALL form one word, with the first byte in bits [7:0] and the fourth in [31:24].
REQ-018: A 2-bit byte counter SHALL wrap from 3 to 0.
REQ-019: On the cycle after the 4th byte is accepted, wr_en SHALL be 1 for exactly one cycle, with wr_addr set to the word index and wr_data set to the assembled word (write latency = 1 cycle).
REQ-020: The word index SHALL start at 0 for each load and increment by 1 after each write.
REQ-021: Memory layout SHALL be: word 0 = numTrain, word 1 = numTest, then 5*numTrain training words, then 5*numTest test words.
REQ-022: A record SHALL be 4 inputs followed by 1 target; payload words SHALL be written unmodified.
REQ-023: The FSM SHALL have states IDLE, HDR_TRAIN, HDR_TEST, CHECK, PAYLOAD, DONE and ERROR.
REQ-024: IDLE SHALL go to HDR_TRAIN on start.
REQ-025: HDR_TRAIN SHALL go to HDR_TEST when word 0 completes.
REQ-026: HDR_TEST SHALL go to CHECK when word 1 completes.
REQ-027: CHECK SHALL last 1 cycle with in_ready=0, and SHALL go to PAYLOAD if the header is valid or to ERROR if it is not.
REQ-028: PAYLOAD SHALL go to DONE when the last payload word has been written.
REQ-029: DONE and ERROR SHALL go to HDR_TRAIN on start and ignore all other input.
REQ-030: The header SHALL be invalid if word0[31:8] != 0, if word1[31:8] != 0, or if numTrain == 0.
REQ-031: The header SHALL be invalid if 2 + 5*(numTrain+numTest) > 2**ADDR_W, with this sum computed in at least 12 bits without overflow.
REQ-032: Header words SHALL be written to memory even if they are invalid.
REQ-033: In ERROR, no further writes SHALL occur.
REQ-034: The remaining-payload counter SHALL be loaded with 5*(numTrain+numTest) in CHECK and decremented on each payload write.
REQ-035: DONE SHALL be entered on the cycle after the write that brings the counter to 0.
REQ-036: If numTest == 0, only training records SHALL be expected.
REQ-037: busy SHALL be 1 in every state except IDLE, DONE and ERROR.
REQ-038: done SHALL be 1 only in DONE, and error SHALL be 1 only in ERROR.
REQ-039: start received while busy SHALL be ignored.
REQ-040: start SHALL clear done, clear error, reset the byte counter and reset the word index.
REQ-041: Bytes presented while in_ready=0 SHALL not be consumed and SHALL not affect state.

Reset
REQ-042: Asserting rst SHALL immediately force state to IDLE and set the byte counter, word index, remaining counter and header registers to 0.
REQ-043: During reset, in_ready, wr_en, busy, done and error SHALL be 0, and wr_addr and wr_data SHALL be 0.
REQ-044: A reset mid-load SHALL abandon the partial word with no write issued, and the next load SHALL restart at word 0.

Structure
REQ-045: Package neural_pkg SHALL hold ADDR_W_DEF=11, DATA_W_DEF=32, HDR_WORDS=2, RECORD_WORDS=5, MEM_WORDS=2048 and the loader state enum.
REQ-046: Sub-module byte_packer SHALL hold the byte counter and shift register and SHALL produce word_valid and word.
REQ-047: The loader FSM, counters and header check SHALL reside in neural_mem_loader.

Verification
REQ-048: Test 1: rst, then start with numTrain=2, numTest=1 and 15 payload words SHALL give 17 writes to addresses 0..16, done=1 and error=0.
REQ-049: Test 2: bytes 0x04,0x03,0x02,0x01 as word 0 SHALL give wr_data=0x01020304 at wr_addr=0 one cycle after the 4th byte.
REQ-050: Test 3: header numTrain=0 SHALL give 2 writes and then error=1, with in_ready=0 thereafter and no further writes.
REQ-051: Test 4: numTrain=255 and numTest=255 (2552 words) SHALL give error=1 after CHECK; numTrain=204, numTest=205 (2047 words) SHALL give done=1.
REQ-052: Test 5: random in_valid gaps and a start pulse mid-load SHALL leave the write sequence unchanged, with start ignored.
REQ-053: Test 6: rst asserted after 2 bytes of payload word 5, then a full valid load, SHALL give a write sequence starting again at address 0, with no stale write.

Source files
------------

// File: rtl/neural_pkg.sv
// Shared constants and the loader state encoding for the neural data-memory loader.
package neural_pkg;
  localparam int ADDR_W_DEF   = 11;
  localparam int DATA_W_DEF   = 32;
  localparam int HDR_WORDS    = 2;
  localparam int RECORD_WORDS = 5;
  localparam int MEM_WORDS    = 2048;

  typedef enum logic [2:0] {
    IDLE, HDR_TRAIN, HDR_TEST, CHECK, PAYLOAD, DONE, ERROR
  } loader_state_e;
endpackage

// File: rtl/byte_packer.sv
// Packs four accepted bytes (little-endian) into one word; word_valid pulses on the 4th byte.
module byte_packer
  import neural_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              accept,
  input  logic [7:0]        in_data,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-9:0] sr_q, sr_d;

  // Bytes shift in from the top so the first byte ends up in the low lane.
  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clr) begin
      cnt_d = 2'd0;
      sr_d  = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = {in_data, sr_q[DATA_W-9:8]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  assign word_valid = accept && !clr && (cnt_q == 2'd3);
  assign word       = {in_data, sr_q};
endmodule

// File: rtl/neural_mem_loader.sv
// Streams a byte image (header + records) into data memory, validating the header sizes.
module neural_mem_loader
  import neural_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int          REM_W   = 13;
  localparam logic [31:0] MEM_LIM = 32'(1) << ADDR_W;

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, w0_q, w0_d, w1_q, w1_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              wr_en_q, wr_en_d;

  logic              accept, pk_clr, pk_valid;
  logic [DATA_W-1:0] pk_word;
  logic [REM_W-1:0]  pay_words;
  logic [31:0]       tot_words;
  logic              hdr_ok;

  assign in_ready = (state_q == HDR_TRAIN) || (state_q == HDR_TEST) || (state_q == PAYLOAD);
  assign accept   = in_valid && in_ready;

  byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (pk_clr),
    .accept    (accept),
    .in_data   (in_data),
    .word_valid(pk_valid),
    .word      (pk_word)
  );

  // 13 bits hold the worst case 2 + 5*(255+255) = 2552 without overflow.
  assign pay_words = REM_W'(RECORD_WORDS) * (REM_W'(w0_q[7:0]) + REM_W'(w1_q[7:0]));
  assign tot_words = 32'(pay_words) + 32'(HDR_WORDS);
  assign hdr_ok    = (w0_q[DATA_W-1:8] == '0) && (w1_q[DATA_W-1:8] == '0) &&
                     (w0_q[7:0] != 8'd0) && (tot_words <= MEM_LIM);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    w0_d      = w0_q;
    w1_d      = w1_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pk_clr    = 1'b0;

    // Every completed word is written one cycle later, header words included.
    if (pk_valid) begin
      wr_en_d   = 1'b1;
      wr_addr_d = idx_q;
      wr_data_d = pk_word;
      idx_d     = idx_q + ADDR_W'(1);
    end

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = HDR_TRAIN;
          idx_d   = '0;
          rem_d   = '0;
          pk_clr  = 1'b1;
        end
      end
      HDR_TRAIN: if (pk_valid) begin
        w0_d    = pk_word;
        state_d = HDR_TEST;
      end
      HDR_TEST: if (pk_valid) begin
        w1_d    = pk_word;
        state_d = CHECK;
      end
      CHECK: begin
        rem_d   = pay_words;
        state_d = hdr_ok ? PAYLOAD : ERROR;
      end
      PAYLOAD: if (wr_en_q) begin
        // Count on the write itself so DONE follows the final write.
        rem_d = rem_q - REM_W'(1);
        if (rem_q == REM_W'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rem_q     <= '0;
      w0_q      <= '0;
      w1_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      w0_q      <= w0_d;
      w1_q      <= w1_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
  assign done    = (state_q == DONE);
  assign error   = (state_q == ERROR);
endmodule

// File: tb/tb_neural_mem_loader.sv
// Directed bench: table of whole-image loads plus hand sequences for byte timing and resets.
module tb_neural_mem_loader;
  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, wr_en, busy, done, error;
  logic [10:0] wr_addr;
  logic [31:0] wr_data;

  neural_mem_loader #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    string       name;
    logic [31:0] w0;
    logic [31:0] w1;
    int          npay;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  n_chk = 0;
  int  n_err = 0;

  always @(negedge clk) if (wr_en) obs_q.push_back('{a: wr_addr, d: wr_data});

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps && $urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
  endtask

  // Runs one image and checks status plus the full write log against the bench's own list.
  task automatic run_load(input vec_t v, input bit gaps, input bit mid_start);
    int          t, nbad;
    logic [31:0] d;
    obs_q.delete();
    exp_q.delete();
    pulse_start();
    send_word(v.w0, gaps);
    exp_q.push_back('{a: 11'd0, d: v.w0});
    send_word(v.w1, gaps);
    exp_q.push_back('{a: 11'd1, d: v.w1});
    for (int i = 0; i < v.npay; i++) begin
      if (mid_start && i == 3) begin
        pulse_start();
        chk({v.name, "_busy_after_start"}, 64'(busy), 64'd1);
      end
      d = 32'h5A00_0000 + 32'(i) * 32'h0001_0203 + 32'(v.npay);
      send_word(d, gaps);
      exp_q.push_back('{a: 11'(i + 2), d: d});
    end
    t = 0;
    while (!(done || error) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({v.name, "_done"},  64'(done),     64'(v.exp_done));
    chk({v.name, "_error"}, 64'(error),    64'(v.exp_err));
    chk({v.name, "_busy"},  64'(busy),     64'd0);
    chk({v.name, "_ready"}, 64'(in_ready), 64'd0);
    if (v.exp_err) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
      repeat (8) @(negedge clk);
      in_valid = 1'b0;
      chk({v.name, "_err_ready"}, 64'(in_ready), 64'd0);
    end
    chk({v.name, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    nbad = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) nbad++;
    chk({v.name, "_bad_writes"}, 64'(nbad), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ready"}, 64'(in_ready), 64'd0);
    chk({nm, "_wr_en"}, 64'(wr_en),    64'd0);
    chk({nm, "_busy"},  64'(busy),     64'd0);
    chk({nm, "_done"},  64'(done),     64'd0);
    chk({nm, "_error"}, 64'(error),    64'd0);
    chk({nm, "_addr"},  64'(wr_addr),  64'd0);
    chk({nm, "_data"},  64'(wr_data),  64'd0);
  endtask

  vec_t vecs[8];
  vec_t t1;

  initial begin
    vecs[0] = '{"t1_2x1",        32'd2,          32'd1,          15,   1'b1, 1'b0};
    vecs[1] = '{"ntrain0",       32'd0,          32'd3,          0,    1'b0, 1'b1};
    vecs[2] = '{"w0_hi",         32'h0000_0102,  32'd1,          0,    1'b0, 1'b1};
    vecs[3] = '{"w1_hi",         32'd1,          32'h0001_0001,  0,    1'b0, 1'b1};
    vecs[4] = '{"big_255",       32'd255,        32'd255,        0,    1'b0, 1'b1};
    vecs[5] = '{"fit_204_205",   32'd204,        32'd205,        2045, 1'b1, 1'b0};
    vecs[6] = '{"ntest0",        32'd1,          32'd0,          5,    1'b1, 1'b0};
    vecs[7] = '{"over_204_206",  32'd204,        32'd206,        0,    1'b0, 1'b1};
    t1 = vecs[0];

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_load(vecs[i], 1'b0, 1'b0);

    // Byte order and single-cycle write latency for word 0.
    obs_q.delete();
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h02, 1'b0);
    chk("t2_no_early_wr", 64'(wr_en), 64'd0);
    send_byte(8'h01, 1'b0);
    chk("t2_wr_en",   64'(wr_en),   64'd1);
    chk("t2_wr_addr", 64'(wr_addr), 64'd0);
    chk("t2_wr_data", 64'(wr_data), 64'h0102_0304);
    @(negedge clk);
    chk("t2_wr_pulse", 64'(wr_en), 64'd0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t2_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random stalls and an ignored start mid-load.
    run_load(t1, 1'b1, 1'b1);

    // Reset two bytes into payload word 5 leaves no stale write.
    obs_q.delete();
    pulse_start();
    send_word(32'd2, 1'b0);
    send_word(32'd1, 1'b0);
    for (int i = 0; i < 3; i++) send_word(32'hC0DE_0000 + 32'(i), 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    chk("t6_pre_writes", 64'(obs_q.size()), 64'd5);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_no_stale", 64'(obs_q.size()), 64'd5);
    run_load(t1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
